glitc_multi_conf_controller: RTL and testbench

//  Parametrised Wishbone-controlled configuration sequencer for NCH downstream GLITC FPGAs.

---
 rtl/glitc_multi_conf_controller_if.sv | 19 +
 rtl/glitc_multi_conf_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_glitc_multi_conf_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/glitc_multi_conf_controller_if.sv
// Wishbone slave bundle for the GLITC configuration controller.
// Signal names are from the slave's point of view.
interface glitc_wb_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [4:0]  adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport master (output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
                    input  dat_o, ack_o, err_o, rty_o);
    modport slave  (input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
                    output dat_o, ack_o, err_o, rty_o);
endinterface

// File: rtl/glitc_multi_conf_controller.sv
// Wishbone-controlled configuration sequencer for NCH GLITC FPGAs.
// Each channel runs its own PROGRAM_B / INIT_B / DONE sequence with bounded waits.
module glitc_conf_ch #(
    parameter int PROG_CYCLES  = 16,
    parameter int TO_BITS      = 24,
    parameter int INIT_TIMEOUT = 4096,
    parameter int DONE_TIMEOUT = 2**24-1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start,
    input  logic       abort,
    input  logic       cfg_set,
    input  logic [3:0] err_clr,
    input  logic       init_sync,
    input  logic       done_sync,
    output logic       prog_b,
    output logic [3:0] state_code,
    output logic [3:0] err,
    output logic       cfg_done,
    output logic       busy,
    output logic       gready
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, PROG = 4'd1, WAIT_INIT = 4'd2, LOAD = 4'd3, READY = 4'd4, ERROR = 4'd5
    } state_t;

    localparam logic [TO_BITS-1:0] PROG_LAST = TO_BITS'(PROG_CYCLES - 1);
    localparam logic [TO_BITS-1:0] INIT_TO   = TO_BITS'(INIT_TIMEOUT);
    localparam logic [TO_BITS-1:0] DONE_TO   = TO_BITS'(DONE_TIMEOUT);

    state_t             state, state_n;
    logic [TO_BITS-1:0] cnt, cnt_n, cnt_inc;
    // err bits: [0] init_to, [1] done_to, [2] crc_err, [3] lost_done
    logic [3:0]         err_set;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_set = 4'b0;
        cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (start) begin
            state_n = PROG;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: ;
                PROG: begin
                    if (cnt == PROG_LAST) begin
                        state_n = WAIT_INIT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                WAIT_INIT: begin
                    if (init_sync) begin
                        state_n = LOAD;
                        cnt_n   = '0;
                    end else if (cnt_inc >= INIT_TO) begin
                        state_n    = ERROR;
                        err_set[0] = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                LOAD: begin
                    // DONE is checked first so it wins over a coincident INIT_B drop
                    if (done_sync) begin
                        state_n = READY;
                    end else if (!init_sync) begin
                        state_n    = ERROR;
                        err_set[2] = 1'b1;
                    end else if (cnt_inc >= DONE_TO) begin
                        state_n    = ERROR;
                        err_set[1] = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                READY: begin
                    if (!done_sync) begin
                        state_n    = ERROR;
                        err_set[3] = 1'b1;
                    end
                end
                ERROR: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            err      <= 4'b0;
            cfg_done <= 1'b0;
            prog_b   <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            prog_b <= (state_n != PROG);
            if (abort || start)
                cfg_done <= 1'b0;
            else if (cfg_set)
                cfg_done <= 1'b1;
            // set wins over a simultaneous write-1-to-clear
            if (start && !abort)
                err <= 4'b0;
            else
                err <= (err & ~err_clr) | err_set;
        end
    end

    assign state_code = state;
    assign busy       = (state == PROG) || (state == WAIT_INIT) || (state == LOAD);
    assign gready     = (state == READY) && cfg_done;
endmodule

module glitc_multi_conf_controller #(
    parameter int NCH          = 4,
    parameter int PROG_CYCLES  = 16,
    parameter int TO_BITS      = 24,
    parameter int INIT_TIMEOUT = 4096,
    parameter int DONE_TIMEOUT = 2**24-1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    glitc_wb_if.slave      wb,
    output logic [NCH-1:0] gready_o,
    output logic           irq_o,
    output logic [NCH-1:0] PROGRAM_B,
    input  logic [NCH-1:0] INIT_B,
    input  logic [NCH-1:0] DONE
);
    logic                  ack_q;
    logic [NCH-1:0]        init_s1, init_sync, done_s1, done_sync;
    logic                  wr, ctrl_wr, err_wr;
    logic [1:0]            word;
    logic [NCH-1:0]        start_v, abort_v, cfg_set_v, cfg_done, busy;
    logic [NCH-1:0][3:0]   err_clr_v, err_v, state_v;
    logic [3:0][7:0]       status_lane, err_lane;
    logic                  unused_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            init_s1   <= '0;
            init_sync <= '0;
            done_s1   <= '0;
            done_sync <= '0;
        end else begin
            ack_q     <= wb.cyc_i & wb.stb_i;
            init_s1   <= INIT_B;
            init_sync <= init_s1;
            done_s1   <= DONE;
            done_sync <= done_s1;
        end
    end

    assign wb.ack_o = ack_q & wb.cyc_i & wb.stb_i;
    assign wb.err_o = 1'b0;
    assign wb.rty_o = 1'b0;

    // Only the first cycle of an access writes, so a held strobe cannot restart PROG twice.
    assign word    = wb.adr_i[3:2];
    assign wr      = wb.cyc_i & wb.stb_i & wb.we_i & ~ack_q;
    assign ctrl_wr = wr && (word == 2'd0);
    assign err_wr  = wr && (word == 2'd1);
    assign unused_ok = &{1'b0, wb.sel_i, wb.adr_i[4], wb.adr_i[1:0], wb.dat_i};

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            start_v[n]   = ctrl_wr & wb.dat_i[n];
            cfg_set_v[n] = ctrl_wr & wb.dat_i[8+n];
            abort_v[n]   = ctrl_wr & wb.dat_i[16+n];
            err_clr_v[n] = err_wr ? {wb.dat_i[24+n], wb.dat_i[16+n], wb.dat_i[8+n], wb.dat_i[n]}
                                  : 4'b0;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        glitc_conf_ch #(
            .PROG_CYCLES  (PROG_CYCLES),
            .TO_BITS      (TO_BITS),
            .INIT_TIMEOUT (INIT_TIMEOUT),
            .DONE_TIMEOUT (DONE_TIMEOUT)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start      (start_v[n]),
            .abort      (abort_v[n]),
            .cfg_set    (cfg_set_v[n]),
            .err_clr    (err_clr_v[n]),
            .init_sync  (init_sync[n]),
            .done_sync  (done_sync[n]),
            .prog_b     (PROGRAM_B[n]),
            .state_code (state_v[n]),
            .err        (err_v[n]),
            .cfg_done   (cfg_done[n]),
            .busy       (busy[n]),
            .gready     (gready_o[n])
        );
    end

    always_comb begin
        status_lane = '0;
        err_lane    = '0;
        for (int n = 0; n < NCH; n++) begin
            status_lane[0][n] = busy[n];
            status_lane[1][n] = cfg_done[n];
            status_lane[2][n] = init_sync[n];
            status_lane[3][n] = done_sync[n];
            for (int b = 0; b < 4; b++)
                err_lane[b][n] = err_v[n][b];
        end
    end

    always_comb begin
        case (word)
            2'd0:    wb.dat_o = status_lane;
            2'd1:    wb.dat_o = err_lane;
            2'd2:    wb.dat_o = 32'(state_v);
            default: wb.dat_o = 32'h0;
        endcase
    end

    assign irq_o = |err_v;
endmodule

// File: tb/tb_glitc_multi_conf_controller.sv
// Directed sequence with randomized timing; expectations come from the register
// map rules (error word model, PROGRAM_B pulse widths from write timestamps).
module tb_glitc_multi_conf_controller;
    localparam int NCH = 4, PC = 16, TOB = 12, ITO = 64, DTO = 300;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] gready, progb;
    logic [NCH-1:0] init_b = '0, done = '0;
    logic           irq;

    glitc_wb_if wb();

    glitc_multi_conf_controller #(
        .NCH(NCH), .PROG_CYCLES(PC), .TO_BITS(TOB), .INIT_TIMEOUT(ITO), .DONE_TIMEOUT(DTO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wb(wb), .gready_o(gready), .irq_o(irq),
        .PROGRAM_B(progb), .INIT_B(init_b), .DONE(done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0;
    int          cyc_cnt = 0, wr_edge = 0;
    int          low_len[NCH] = '{default: 0};
    int          last_pulse[NCH] = '{default: 0};
    logic [31:0] exp_err, rd, r;
    int          w1, w2, d, n;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // PROGRAM_B low-pulse width monitor, in clock cycles
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (progb[i] === 1'b0) low_len[i] = low_len[i] + 1;
            else if (low_len[i] != 0) begin
                last_pulse[i] = low_len[i];
                low_len[i] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] dat);
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = a; wb.dat_i = dat;
        @(negedge clk);
        wr_edge = cyc_cnt;
        chk("wr_ack", {31'b0, wb.ack_o}, 32'h1);
        @(negedge clk);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = a;
        @(negedge clk);
        chk({tag, "_ack"}, {31'b0, wb.ack_o}, 32'h1);
        chk(tag, wb.dat_o, exp);
        @(negedge clk);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
    endtask

    task automatic wait_progb_high(input int ch, input string tag);
        int k = 0;
        while (progb[ch] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'b0, progb[ch]}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        wb.adr_i = '0; wb.sel_i = 4'hF; wb.dat_i = '0;
        exp_err = '0;

        // 1: reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_progb", 32'(progb), 32'hF);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_gready", 32'(gready), 32'h0);
        rd_chk("rst_status", 5'h00, 32'h0);
        rd_chk("rst_err", 5'h04, 32'h0);
        rd_chk("rst_state", 5'h08, 32'h0);
        wb_write(5'h0C, 32'hFFFF_FFFF);
        chk("wr0c_progb", 32'(progb), 32'hF);
        rd_chk("rd0c", 5'h0C, 32'h0);

        // 2: normal configuration on ch0
        wb_write(5'h00, 32'h1);
        wait_progb_high(0, "ch0_prog_release");
        tick(1);
        chk("ch0_prog_width", 32'(last_pulse[0]), 32'(PC));
        rd_chk("ch0_wait_init", 5'h08, 32'h2);
        d = $urandom_range(12, 2);
        tick(d);
        init_b[0] = 1'b1;
        tick(4);
        rd_chk("ch0_load", 5'h08, 32'h3);
        rd_chk("ch0_status_load", 5'h00, 32'h0001_0001);
        done[0] = 1'b1;
        tick(4);
        rd_chk("ch0_ready", 5'h08, 32'h4);
        chk("ch0_gready_nocfg", 32'(gready), 32'h0);
        wb_write(5'h00, 32'h100);
        chk("ch0_gready", 32'(gready), 32'h1);
        rd_chk("ch0_status_ready", 5'h00, 32'h0101_0100);

        // 3: INIT timeout on ch2
        wb_write(5'h00, 32'h4);
        wait_progb_high(2, "ch2_prog_release");
        n = 0;
        while (irq !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ch2_init_to_latency", 32'(n), 32'(ITO));
        exp_err = exp_err | 32'h4;
        rd_chk("ch2_err", 5'h04, exp_err);
        rd_chk("ch2_state", 5'h08, 32'h0000_0504);
        wb_write(5'h04, 32'h4);
        exp_err = exp_err & ~32'h4;
        chk("ch2_irq_clr", {31'b0, irq}, 32'h0);
        rd_chk("ch2_err_clr", 5'h04, exp_err);

        // 4a: CRC error on ch1
        wb_write(5'h00, 32'h2);
        wait_progb_high(1, "ch1_prog_release");
        tick($urandom_range(10, 1));
        init_b[1] = 1'b1;
        tick(4);
        rd_chk("ch1_load", 5'h08, 32'h0000_0534);
        init_b[1] = 1'b0;
        tick(4);
        exp_err = exp_err | 32'h0002_0000;
        chk("ch1_irq", {31'b0, irq}, 32'h1);
        rd_chk("ch1_crc_err", 5'h04, exp_err);
        rd_chk("ch1_state", 5'h08, 32'h0000_0554);
        r = $urandom;
        wb_write(5'h04, r);
        exp_err = exp_err & ~r;
        rd_chk("rand_w1c", 5'h04, exp_err);
        wb_write(5'h04, 32'hFFFF_FFFF);
        exp_err = '0;
        chk("w1c_all_irq", {31'b0, irq}, 32'h0);

        // 4b: lost DONE on ch3
        init_b[3] = 1'b1;
        done[3] = 1'b1;
        wb_write(5'h00, 32'h8);
        wait_progb_high(3, "ch3_prog_release");
        tick(4);
        rd_chk("ch3_ready", 5'h08, 32'h0000_4554);
        wb_write(5'h00, 32'h800);
        chk("ch3_gready", 32'(gready), 32'h9);
        done[3] = 1'b0;
        tick(4);
        exp_err = exp_err | 32'h0800_0000;
        rd_chk("ch3_lost_done", 5'h04, exp_err);
        chk("ch3_gready_drop", 32'(gready), 32'h1);

        // 5: abort beats start; restart while busy
        wb_write(5'h00, 32'h0001_0001);
        chk("abort_start_progb0", {31'b0, progb[0]}, 32'h1);
        tick(3);
        chk("abort_progb_all", 32'(progb), 32'hF);
        rd_chk("abort_state", 5'h08, 32'h0000_5550);
        chk("abort_gready", 32'(gready), 32'h0);
        rd_chk("abort_status", 5'h00, 32'h0109_0800);
        wb_write(5'h00, 32'hF);
        w1 = wr_edge;
        tick($urandom_range(6, 2));
        rd_chk("all_prog_state", 5'h08, 32'h0000_1111);
        exp_err = '0;
        rd_chk("start_clears_err", 5'h04, exp_err);
        wb_write(5'h00, 32'hF);
        w2 = wr_edge;
        for (int i = 0; i < NCH; i++) wait_progb_high(i, "restart_release");
        tick(1);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("restart_width%0d", i), 32'(last_pulse[i]), 32'(w2 - w1 + PC));
        tick(200);
        exp_err = 32'h6;
        rd_chk("init_to_ch12", 5'h04, exp_err);
        tick(120);
        exp_err = exp_err | 32'h800;
        rd_chk("done_to_ch3", 5'h04, exp_err);
        rd_chk("final_state", 5'h08, 32'h0000_5554);

        // 6: reset during PROG
        wb_write(5'h00, 32'h1);
        tick(3);
        chk("midprog_low", {31'b0, progb[0]}, 32'h0);
        rst = 1'b1;
        tick(1);
        chk("midprog_release", {31'b0, progb[0]}, 32'h1);
        rst = 1'b0;
        tick(1);
        chk("midprog_width", 32'(last_pulse[0]), 32'h5);
        rd_chk("midprog_state", 5'h08, 32'h0);
        rd_chk("midprog_err", 5'h04, 32'h0);
        chk("midprog_irq", {31'b0, irq}, 32'h0);
        chk("midprog_progb", 32'(progb), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
